fifo_reader: RTL and testbench

Read-side master for the synchronous FIFO. Drives `rd_en`, captures the registered `data_out` one cycle later into a small internal skid buffer, and presents the words as a valid/ready stream. Sustains one word per cycle with no combinational path from `m_ready` to `rd_en`. Sits between the FIFO's read port and any downstream consumer, and also provides enable/drain control, a delivered-word counter and a sticky underflow error.

---
 rtl/fifo_reader.sv | 112 +++++++++++
 tb/tb_fifo_reader.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_reader.sv
// Read-side master for a synchronous FIFO: issues rd_en, captures the registered
// read data into a small circular skid buffer and presents it as a valid/ready stream.
//
// state | meaning
// IDLE  | no reads issued, waiting for en
// RUN   | reads issued whenever the FIFO has data and the buffer has room
// DRAIN | no new reads; in-flight and buffered words still delivered
module fifo_reader #(
    parameter int FIFO_WIDTH = 16,
    parameter int BUF_DEPTH  = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  empty,
    input  logic                  underflow,
    input  logic [FIFO_WIDTH-1:0] data_out,
    output logic                  rd_en,
    output logic [FIFO_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  busy,
    output logic [15:0]           rd_count,
    output logic                  err_underflow
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                  state_q, state_d;
    logic                    inflight_q;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
    logic [FIFO_WIDTH-1:0]   buf_q [BUF_DEPTH];
    logic [15:0]             rd_count_q;
    logic                    err_q;
    logic                    push, pop;
    logic [CNT_W:0]          occupancy;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(BUF_DEPTH - 1)) return '0;
        return p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (en) state_d = RUN;
            RUN:     if (!en) state_d = DRAIN;
            DRAIN: begin
                if (en)                                   state_d = RUN;
                else if (!inflight_q && cnt_q == '0)      state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Occupancy counts the in-flight word so a push can never land on a full buffer.
    always_comb begin
        occupancy = {1'b0, cnt_q} + {{CNT_W{1'b0}}, inflight_q};
        rd_en     = (state_q == RUN) && !empty && (occupancy < (CNT_W + 1)'(BUF_DEPTH));
        busy      = (state_q != IDLE);
    end

    assign m_valid       = (cnt_q != '0);
    assign m_data        = buf_q[rd_ptr_q];
    assign rd_count      = rd_count_q;
    assign err_underflow = err_q;
    assign push          = inflight_q && !underflow;
    assign pop           = m_valid && m_ready;

    always_comb begin
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q <= 1'b0;
            cnt_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rd_count_q <= '0;
            err_q      <= 1'b0;
            for (int i = 0; i < BUF_DEPTH; i++) buf_q[i] <= '0;
        end else begin
            inflight_q <= rd_en;
            cnt_q      <= cnt_d;
            if (push) begin
                buf_q[wr_ptr_q] <= data_out;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q   <= ptr_inc(rd_ptr_q);
                rd_count_q <= rd_count_q + 16'd1;
            end
            if (inflight_q && underflow) err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_reader.sv
// Directed bench for fifo_reader with a behavioural registered-output FIFO model.
module tb_fifo_reader;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        empty;
    logic        underflow;
    logic [15:0] data_out;
    logic        rd_en;
    logic [15:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic        busy;
    logic [15:0] rd_count;
    logic        err_underflow;

    int checks = 0;
    int errors = 0;

    // FIFO model: tb writes loaded/base, model advances taken.
    int fifo_loaded = 0;
    int fifo_base   = 0;
    int fifo_taken  = 0;
    logic uf_force  = 1'b0;

    fifo_reader #(.FIFO_WIDTH(16), .BUF_DEPTH(3)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .empty         (empty),
        .underflow     (underflow),
        .data_out      (data_out),
        .rd_en         (rd_en),
        .m_data        (m_data),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .busy          (busy),
        .rd_count      (rd_count),
        .err_underflow (err_underflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign empty = (fifo_taken == fifo_loaded);

    always @(posedge clk) begin
        underflow <= rd_en && uf_force;
        if (rd_en && (fifo_taken != fifo_loaded)) begin
            data_out   <= 16'(fifo_taken - fifo_base + 1);
            fifo_taken <= fifo_taken + 1;
        end
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %04h expected %04h", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        en       = 1'b0;
        m_ready  = 1'b0;
        uf_force = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic load(input int n);
        fifo_base   = fifo_taken;
        fifo_loaded = fifo_taken + n;
    endtask

    // Pops words while m_ready=1, checking each against first_word + index.
    task automatic collect(input string tag, input int n, input int first_word);
        int got;
        got = 0;
        for (int cyc = 0; cyc < 60 && got < n; cyc++) begin
            if (m_valid) begin
                chk16(tag, m_data, 16'(first_word + got));
                got++;
            end
            @(negedge clk);
        end
        chk32({tag, "_count"}, got, n);
    endtask

    initial begin
        int pulses;
        int cyc;
        rst_n = 1'b0;
        en = 1'b0;
        m_ready = 1'b0;

        // Reset values
        do_reset();
        chk1("rst_rd_en", rd_en, 1'b0);
        chk1("rst_m_valid", m_valid, 1'b0);
        chk16("rst_m_data", m_data, 16'h0000);
        chk1("rst_busy", busy, 1'b0);
        chk16("rst_rd_count", rd_count, 16'h0000);
        chk1("rst_err", err_underflow, 1'b0);

        // Streaming: reads at cycles 1..8, words out at cycles 3..10
        load(8);
        en = 1'b1;
        m_ready = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            chk1("stream_rd_en", rd_en, (i <= 8));
            chk1("stream_m_valid", m_valid, (i >= 3 && i <= 10));
            if (i >= 3 && i <= 10) chk16("stream_m_data", m_data, 16'(i - 2));
        end
        chk16("stream_rd_count", rd_count, 16'd8);
        en = 1'b0;
        repeat (3) @(negedge clk);
        chk1("stream_idle_busy", busy, 1'b0);

        // Backpressure: exactly three reads, head word held, then full delivery
        do_reset();
        load(8);
        en = 1'b1;
        m_ready = 1'b0;
        pulses = 0;
        repeat (6) begin
            @(negedge clk);
            if (rd_en) pulses++;
        end
        chk32("bp_pulses", pulses, 3);
        chk1("bp_rd_en_off", rd_en, 1'b0);
        chk1("bp_m_valid", m_valid, 1'b1);
        chk16("bp_m_data_held", m_data, 16'h0001);
        chk32("bp_fifo_left", fifo_loaded - fifo_taken, 5);
        @(negedge clk);
        chk16("bp_m_data_held2", m_data, 16'h0001);
        m_ready = 1'b1;
        collect("bp_data", 8, 1);
        chk16("bp_rd_count", rd_count, 16'd8);
        chk1("bp_m_valid_end", m_valid, 1'b0);

        // Drain with one read in flight and two words buffered
        do_reset();
        load(8);
        en = 1'b1;
        m_ready = 1'b0;
        repeat (4) @(negedge clk);
        en = 1'b0;
        m_ready = 1'b1;
        chk1("dr_m_valid0", m_valid, 1'b1);
        chk16("dr_m_data0", m_data, 16'h0001);
        @(negedge clk);
        chk16("dr_m_data1", m_data, 16'h0002);
        chk1("dr_rd_en1", rd_en, 1'b0);
        chk1("dr_busy1", busy, 1'b1);
        @(negedge clk);
        chk16("dr_m_data2", m_data, 16'h0003);
        chk1("dr_rd_en2", rd_en, 1'b0);
        @(negedge clk);
        chk1("dr_m_valid3", m_valid, 1'b0);
        chk1("dr_busy3", busy, 1'b1);
        chk1("dr_rd_en3", rd_en, 1'b0);
        @(negedge clk);
        chk1("dr_busy4", busy, 1'b0);
        chk16("dr_rd_count", rd_count, 16'd3);
        chk32("dr_fifo_left", fifo_loaded - fifo_taken, 5);

        // Underflow on the first returned word
        do_reset();
        load(4);
        uf_force = 1'b1;
        en = 1'b1;
        m_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        uf_force = 1'b0;
        @(negedge clk);
        chk1("uf_err_set", err_underflow, 1'b1);
        chk1("uf_no_push", m_valid, 1'b0);
        @(negedge clk);
        collect("uf_data", 3, 2);
        chk1("uf_err_sticky", err_underflow, 1'b1);
        en = 1'b0;
        repeat (3) @(negedge clk);
        chk1("uf_err_sticky2", err_underflow, 1'b1);
        do_reset();
        chk1("uf_err_cleared", err_underflow, 1'b0);

        // Asynchronous reset between edges with two words buffered
        load(8);
        en = 1'b1;
        m_ready = 1'b0;
        repeat (4) @(negedge clk);
        chk1("ar_pre_valid", m_valid, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk1("ar_rd_en", rd_en, 1'b0);
        chk1("ar_m_valid", m_valid, 1'b0);
        chk16("ar_m_data", m_data, 16'h0000);
        chk1("ar_busy", busy, 1'b0);
        chk16("ar_rd_count", rd_count, 16'h0000);
        chk1("ar_err", err_underflow, 1'b0);
        en = 1'b0;
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk1("ar_stale_valid", m_valid, 1'b0);
        @(negedge clk);
        chk1("ar_stale_valid2", m_valid, 1'b0);
        chk1("ar_idle", busy, 1'b0);
        en = 1'b1;
        m_ready = 1'b1;
        collect("ar_data", 5, 4);
        chk16("ar_rd_count_end", rd_count, 16'd5);
        en = 1'b0;

        // Delivered-word counter wrap
        do_reset();
        load(65536);
        en = 1'b1;
        m_ready = 1'b1;
        cyc = 0;
        while (rd_count !== 16'hFFFF && cyc < 70000) begin
            @(negedge clk);
            cyc++;
        end
        chk16("wrap_reach_ffff", rd_count, 16'hFFFF);
        m_ready = 1'b0;
        en = 1'b0;
        @(negedge clk);
        chk16("wrap_hold", rd_count, 16'hFFFF);
        chk1("wrap_m_valid", m_valid, 1'b1);
        chk16("wrap_m_data", m_data, 16'h0000);
        m_ready = 1'b1;
        @(negedge clk);
        chk16("wrap_zero", rd_count, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
